// File: rtl/gpio_pattern_tx.sv
// Purpose : serialises a latched 32-bit pattern LSB-first on a data/strobe pin pair, repeated N times.
// Latency : first bit appears one cycle after start_i is accepted; done_o pulses the cycle after the last HIGH phase.
// Backpr. : none; start_i is only sampled in IDLE and otherwise ignored, abort_i returns to IDLE next cycle.
//
// Ports
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   start_i, abort_i    : transfer request (IDLE only) / synchronous abort (priority over start)
//   pattern_i, len_i    : bits to send and bit count minus one
//   repeat_i            : extra passes of the pattern (total passes = repeat_i + 1)
//   div_i               : half-period length minus one, in clk_i cycles
//   pol_i               : idle level of the strobe pin
//   cio_data_o/strb_o   : serial data and strobe pins
//   cio_en_o            : pin output enables {strb, data}
//   busy_o, done_o      : transfer active / one-cycle completion pulse
module gpio_pattern_tx #(
  parameter int unsigned DivWidth = 16,
  parameter int unsigned MaxBits  = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [MaxBits-1:0]  pattern_i,
  input  logic [4:0]          len_i,
  input  logic [7:0]          repeat_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic                pol_i,
  output logic                cio_data_o,
  output logic                cio_strb_o,
  output logic [1:0]          cio_en_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;

  logic [1:0]          state_q;

  // Transfer parameters captured at acceptance so later input changes are invisible.
  logic [MaxBits-1:0]  pat_q;
  logic [4:0]          len_q;
  logic [DivWidth-1:0] div_q;
  logic                pol_q;

  logic [DivWidth-1:0] half_cnt_q;
  logic [4:0]          bit_idx_q;
  logic [7:0]          pass_cnt_q;

  // Output flops; every pin is a register.
  logic                data_q;
  logic                strb_q;
  logic [1:0]          en_q;
  logic                busy_q;
  logic                done_q;

  logic                half_done;
  logic                last_bit;
  logic                last_pass;
  logic [4:0]          bit_idx_nxt;

  // half_cnt counts 0..div_q, so each phase lasts div_q+1 cycles and never wraps.
  assign half_done   = (half_cnt_q == div_q);
  assign last_bit    = (bit_idx_q == len_q);
  assign last_pass   = (pass_cnt_q == 8'd0);
  assign bit_idx_nxt = bit_idx_q + 5'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pat_q      <= '0;
      len_q      <= '0;
      div_q      <= '0;
      pol_q      <= 1'b0;
      half_cnt_q <= '0;
      bit_idx_q  <= '0;
      pass_cnt_q <= '0;
      data_q     <= 1'b0;
      strb_q     <= 1'b0;
      en_q       <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        // Abort wins over everything, including a same-cycle start.
        state_q    <= StIdle;
        half_cnt_q <= '0;
        bit_idx_q  <= '0;
        pass_cnt_q <= '0;
        data_q     <= 1'b0;
        strb_q     <= pol_q;
        en_q       <= 2'b00;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              state_q    <= StLow;
              pat_q      <= pattern_i;
              len_q      <= len_i;
              div_q      <= div_i;
              pol_q      <= pol_i;
              half_cnt_q <= '0;
              bit_idx_q  <= '0;
              pass_cnt_q <= repeat_i;
              // Drive the first bit from the live inputs so it lands with LOW entry.
              data_q     <= pattern_i[0];
              strb_q     <= pol_i;
              en_q       <= 2'b11;
              busy_q     <= 1'b1;
            end
          end

          StLow: begin
            if (half_done) begin
              state_q    <= StHigh;
              half_cnt_q <= '0;
              strb_q     <= ~pol_q;
            end else begin
              half_cnt_q <= half_cnt_q + 1'b1;
            end
          end

          StHigh: begin
            if (half_done) begin
              half_cnt_q <= '0;
              if (!last_bit) begin
                state_q   <= StLow;
                bit_idx_q <= bit_idx_nxt;
                data_q    <= pat_q[bit_idx_nxt];
                strb_q    <= pol_q;
              end else if (!last_pass) begin
                // Next pass starts immediately, no gap cycle.
                state_q    <= StLow;
                bit_idx_q  <= '0;
                pass_cnt_q <= pass_cnt_q - 8'd1;
                data_q     <= pat_q[0];
                strb_q     <= pol_q;
              end else begin
                state_q   <= StIdle;
                bit_idx_q <= '0;
                data_q    <= 1'b0;
                strb_q    <= pol_q;
                en_q      <= 2'b00;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
              end
            end else begin
              half_cnt_q <= half_cnt_q + 1'b1;
            end
          end

          default: begin
            state_q <= StIdle;
            data_q  <= 1'b0;
            strb_q  <= pol_q;
            en_q    <= 2'b00;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cio_data_o = data_q;
  assign cio_strb_o = strb_q;
  assign cio_en_o   = en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_gpio_pattern_tx.sv
// Purpose : randomized and directed checks of gpio_pattern_tx against a cycle-list reference model.
// Latency : n/a (testbench).
// Backpr. : n/a (testbench).
module tb_gpio_pattern_tx;

  localparam int DW = 12;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          abort   = 1'b0;
  logic [31:0]   pat     = '0;
  logic [4:0]    len     = '0;
  logic [7:0]    rep     = '0;
  logic [DW-1:0] div     = '0;
  logic          pol     = 1'b0;
  logic          data;
  logic          strb;
  logic [1:0]    en;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_pattern_tx #(.DivWidth(DW), .MaxBits(32)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .abort_i   (abort),
    .pattern_i (pat),
    .len_i     (len),
    .repeat_i  (rep),
    .div_i     (div),
    .pol_i     (pol),
    .cio_data_o(data),
    .cio_strb_o(strb),
    .cio_en_o  (en),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scramble inputs while busy: none of this may influence the running transfer.
  task automatic drive_random();
    start = 1'($urandom);
    pat   = $urandom;
    len   = 5'($urandom);
    rep   = 8'($urandom);
    div   = DW'($urandom);
    pol   = 1'($urandom);
  endtask

  // Observed vector layout: {done, busy, en[1:0], strb, data}
  // Expects to be called at a negedge. pre_started: start already accepted on the previous edge.
  // chain: hold start with the same config in the done cycle. abort_at/rst_at: cycle index to
  // abort or reset in (-1 = never).
  task automatic xfer(input string name, input logic [31:0] p, input logic [4:0] l,
                      input logic [7:0] r, input logic [DW-1:0] d, input logic po,
                      input bit pre_started, input bit chain, input int abort_at, input int rst_at);
    logic [5:0] q[$];
    logic [5:0] idle_v;
    int         hp;
    int         busy_seen;
    hp        = int'(d) + 1;
    busy_seen = 0;
    idle_v    = {1'b0, 1'b0, 2'b00, po, 1'b0};
    // Reference: every pass, every bit, a LOW half then a HIGH half, then one done cycle.
    for (int ps = 0; ps <= int'(r); ps++)
      for (int b = 0; b <= int'(l); b++)
        for (int k = 0; k < 2 * hp; k++)
          q.push_back({1'b0, 1'b1, 2'b11, (k < hp) ? po : ~po, p[b]});
    q.push_back({1'b1, 1'b0, 2'b00, po, 1'b0});

    if (!pre_started) begin
      pat = p; len = l; rep = r; div = d; pol = po; start = 1'b1;
      @(negedge clk);
    end

    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), {done, busy, en, strb, data}, q[i]);
      if (busy) busy_seen++;
      if (i == q.size() - 1) begin
        if (chain) begin
          pat = p; len = l; rep = r; div = d; pol = po; start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end else begin
        drive_random();
      end
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        check({name, "_abort"}, {done, busy, en, strb, data}, idle_v);
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check({name, "_abort_idle"}, {done, busy, en, strb, data}, idle_v);
        return;
      end
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check({name, "_rst_async"}, {done, busy, en, strb, data}, 32'h0);
        start = 1'b0;
        @(negedge clk);
        check({name, "_rst_hold"}, {done, busy, en, strb, data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check({name, "_rst_idle"}, {done, busy, en, strb, data}, 32'h0);
        return;
      end
      @(negedge clk);
    end
    check({name, "_busy_cnt"}, busy_seen, (int'(r) + 1) * (int'(l) + 1) * 2 * hp);
    if (!chain)
      check({name, "_post_idle"}, {done, busy, en, strb, data}, idle_v);
  endtask

  initial begin
    logic [31:0]   rp;
    logic [4:0]    rl;
    logic [7:0]    rr;
    logic [DW-1:0] rd;
    logic          rpo;
    bit            pend;
    bit            ch;

    repeat (2) @(negedge clk);
    check("reset_state", {done, busy, en, strb, data}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", {done, busy, en, strb, data}, 32'h0);

    xfer("basic", 32'hA, 5'd3, 8'd0, DW'(0), 1'b0, 1'b0, 1'b0, -1, -1);
    xfer("repeat3", 32'h1, 5'd0, 8'd2, DW'(2), 1'b1, 1'b0, 1'b0, -1, -1);

    rp = $urandom;
    xfer("b2b_a", rp, 5'd1, 8'd0, DW'(0), 1'b0, 1'b0, 1'b1, -1, -1);
    xfer("b2b_b", rp, 5'd1, 8'd0, DW'(0), 1'b0, 1'b1, 1'b0, -1, -1);

    // Abort and start together in IDLE: abort must win.
    pat = $urandom; len = 5'd2; rep = 8'd0; div = DW'(1); pol = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("prio_busy", busy, 1'b0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("prio_idle", busy, 1'b0);

    xfer("abort", $urandom, 5'd31, 8'd0, DW'(1), 1'b0, 1'b0, 1'b0, 4, -1);
    xfer("rst_mid", $urandom, 5'd31, 8'd1, DW'(1), 1'b1, 1'b0, 1'b0, -1, 6);
    xfer("ones", 32'hFFFF_FFFF, 5'd31, 8'd0, DW'(0), 1'b0, 1'b0, 1'b0, -1, -1);
    xfer("max_div", $urandom, 5'd0, 8'd0, {DW{1'b1}}, 1'b0, 1'b0, 1'b0, -1, -1);
    xfer("rep255", $urandom, 5'd0, 8'd255, DW'(0), 1'b1, 1'b0, 1'b0, -1, -1);

    pend = 1'b0;
    rp = '0; rl = '0; rr = '0; rd = '0; rpo = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (!pend) begin
        rp  = $urandom;
        rl  = 5'($urandom);
        rr  = 8'($urandom_range(0, 3));
        rd  = DW'($urandom_range(0, 3));
        rpo = 1'($urandom);
      end
      ch = ($urandom_range(0, 3) == 0);
      xfer($sformatf("rnd%0d", t), rp, rl, rr, rd, rpo, pend, ch, -1, -1);
      pend = ch;
    end
    if (pend)
      xfer("rnd_tail", rp, rl, rr, rd, rpo, 1'b1, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
